// File: rtl/register_file_mp.sv
// register_file_mp
// -----------------------------------------------------------------------------
// Multi-read-port register file with a hardware clear sequencer.
//
// The decoder supplies one write address and ReadPorts read addresses. Reads
// are combinational and feed the ALU. A write to the same address in the same
// cycle is forwarded straight to the read port, so the new value is visible
// without waiting for the clock edge.
//
// After reset, or when ClearRequest is seen in IDLE, a sweep writes zero to one
// entry per cycle. A full sweep takes RegisterHeight cycles. While the sweep
// runs:
//   - Busy is high.
//   - Every read port returns zero.
//   - Host writes and further clear requests are ignored.
// ClearDone pulses for one cycle after the last entry has been cleared.
//
// Ports
//   Clock         system clock, rising edge
//   Reset         asynchronous, active-high
//   ClearRequest  level; starts a sweep when sampled high in IDLE
//   WriteEnable   write strobe
//   WriteAddress  [AddressWidth]            register to write
//   WriteData     [RegisterWidth]           data to write
//   ReadAddress   [ReadPorts*AddressWidth]  packed; port p at [p*AW +: AW]
//   ReadData      [ReadPorts*RegisterWidth] packed; port p at [p*RW +: RW]
//   Busy          high while the sweep runs
//   ClearDone     one-cycle pulse when a sweep completes
//
// Build option
//   REGFILE_ZERO_REG_EN  when defined, register 0 is hardwired to zero.
//                        Writes to it are dropped, and every read of it
//                        returns zero, bypass included.
// -----------------------------------------------------------------------------
module register_file_mp #(
  parameter int AddressWidth   = 6,
  parameter int RegisterHeight = 1 << AddressWidth,
  parameter int RegisterWidth  = 16,
  parameter int ReadPorts      = 2
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               ClearRequest,
  input  logic                               WriteEnable,
  input  logic [AddressWidth-1:0]            WriteAddress,
  input  logic [RegisterWidth-1:0]           WriteData,
  input  logic [ReadPorts*AddressWidth-1:0]  ReadAddress,
  output logic [ReadPorts*RegisterWidth-1:0] ReadData,
  output logic                               Busy,
  output logic                               ClearDone
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroRegEn = 1'b1;
`else
  localparam bit ZeroRegEn = 1'b0;
`endif

  // The height is widened by one bit so that the range check also works
  // when RegisterHeight == 2**AddressWidth.
  localparam logic [AddressWidth:0]   HeightExt = (AddressWidth + 1)'(RegisterHeight);
  localparam logic [AddressWidth-1:0] LastIndex = AddressWidth'(RegisterHeight - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] clear_index_q, clear_index_d;
  logic                    clear_done_q, clear_done_d;

  logic [RegisterWidth-1:0] regs [RegisterHeight];

  logic                     mem_we;
  logic [AddressWidth-1:0]  mem_waddr;
  logic [RegisterWidth-1:0] mem_wdata;

  function automatic logic in_range(input logic [AddressWidth-1:0] addr);
    return {1'b0, addr} < HeightExt;
  endfunction

  // Register 0 is not writable or readable as data when it is hardwired.
  function automatic logic is_zero_reg(input logic [AddressWidth-1:0] addr);
    return ZeroRegEn && (addr == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_CLEAR;
      clear_index_q <= '0;
      clear_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
      clear_done_q  <= clear_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    clear_index_d = clear_index_q;
    clear_done_d  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // The index stops at the last entry and never wraps.
        if (clear_index_q == LastIndex) begin
          state_d       = ST_IDLE;
          clear_index_d = '0;
          clear_done_d  = 1'b1;
        end else begin
          clear_index_d = clear_index_q + AddressWidth'(1);
        end
      end
      default: begin
        if (ClearRequest) begin
          state_d       = ST_CLEAR;
          clear_index_d = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy      = (state_q == ST_CLEAR);
    ClearDone = clear_done_q;
  end

  // ---------------------------------------------------------------------------
  // Single write port, shared by the sweep and the host.
  // The sweep owns the port while it runs, so host writes made during the
  // sweep are dropped rather than deferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WriteAddress;
    mem_wdata = WriteData;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clear_index_q;
      mem_wdata = '0;
    end else begin
      mem_we = WriteEnable && in_range(WriteAddress) && !is_zero_reg(WriteAddress);
    end
  end

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      regs[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read ports with write-through bypass.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < ReadPorts; gi++) begin : g_read
    logic [AddressWidth-1:0]  raddr;
    logic [RegisterWidth-1:0] rdata;

    assign raddr = ReadAddress[gi*AddressWidth +: AddressWidth];

    always_comb begin
      rdata = '0;
      if ((state_q == ST_IDLE) && in_range(raddr) && !is_zero_reg(raddr)) begin
        if (WriteEnable && (raddr == WriteAddress)) begin
          rdata = WriteData;
        end else begin
          rdata = regs[raddr];
        end
      end
    end

    assign ReadData[gi*RegisterWidth +: RegisterWidth] = rdata;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp.
// Two instances are exercised:
//   - The default configuration: 64 x 16, with 2 read ports.
//   - A 48-entry configuration with 4 read ports, using 6-bit addresses.
module tb_register_file_mp;
  localparam int AW = 6;
  localparam int W  = 16;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [15:0] Reg0Exp = 16'h0000;
`else
  localparam logic [15:0] Reg0Exp = 16'hFFFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic            rst, clr_req, we;
  logic [AW-1:0]   wa;
  logic [W-1:0]    wd;
  logic [2*AW-1:0] ra;
  logic [2*W-1:0]  rd;
  logic            busy, done;

  // 48-entry, 4-port instance
  logic            rst_b, clr_b, we_b;
  logic [AW-1:0]   wa_b;
  logic [W-1:0]    wd_b;
  logic [4*AW-1:0] ra_b;
  logic [4*W-1:0]  rd_b;
  logic            busy_b, done_b;

  register_file_mp dut (
    .Clock(clk), .Reset(rst), .ClearRequest(clr_req), .WriteEnable(we),
    .WriteAddress(wa), .WriteData(wd), .ReadAddress(ra), .ReadData(rd),
    .Busy(busy), .ClearDone(done)
  );

  register_file_mp #(
    .AddressWidth(6), .RegisterHeight(48), .RegisterWidth(16), .ReadPorts(4)
  ) dut48 (
    .Clock(clk), .Reset(rst_b), .ClearRequest(clr_b), .WriteEnable(we_b),
    .WriteAddress(wa_b), .WriteData(wd_b), .ReadAddress(ra_b), .ReadData(rd_b),
    .Busy(busy_b), .ClearDone(done_b)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];

  function automatic logic [15:0] port(input logic [63:0] v, input int p);
    return v[p*16 +: 16];
  endfunction

  // Pops the oldest expected value and compares the observation against it.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      $display("chk %-18s observed %h expected %h", tag, obs, exp);
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until Busy falls (bounded).
  // Also counts any ClearDone seen while Busy was still high.
  task automatic wait_sweep(input bit sel, output int cycles, output int early);
    cycles = 0;
    early  = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cycles++;
      if ((sel ? busy_b : busy) == 1'b0) break;
      if (sel ? done_b : done) early++;
    end
  endtask

  initial begin
    int c, e, nz;
    rst = 1'b1; clr_req = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    rst_b = 1'b1; clr_b = 1'b0; we_b = 1'b0; wa_b = '0; wd_b = '0; ra_b = '0;
    tick(); tick();

    // --- Reset state --------------------------------------------------------
    sb.push_back(1); check("rst_busy", busy);
    sb.push_back(0); check("rst_done", done);
    sb.push_back(0); check("rst_rdata", rd);

    // --- Power-up sweep ------------------------------------------------------
    rst = 1'b0;
    wait_sweep(1'b0, c, e);
    sb.push_back(64); check("sweep_len", c);
    sb.push_back(0);  check("sweep_early_done", e);
    sb.push_back(1);  check("done_pulse", done);
    nz = 0;
    for (int a = 0; a < 64; a++) begin
      ra = {6'(63 - a), 6'(a)};
      tick();
      if (a == 0) begin
        sb.push_back(0); check("done_single", done);
      end
      if (rd !== '0) nz++;
    end
    sb.push_back(0); check("post_clear_nz", nz);

    // --- Write / read / bypass -----------------------------------------------
    we = 1'b1; wa = 6'd5; wd = 16'hBEEF;
    sb.push_back(16'hBEEF); sb.push_back(16'hBEEF);
    tick();
    we = 1'b0; ra = {6'd5, 6'd5}; #1;
    check("rd5_p0", port(rd, 0));
    check("rd5_p1", port(rd, 1));

    we = 1'b1; wa = 6'd7; wd = 16'h1234; ra = {6'd5, 6'd7};
    sb.push_back(16'h1234); sb.push_back(16'hBEEF); #1;
    check("bypass7_p0", port(rd, 0));
    check("bypass7_p1", port(rd, 1));
    tick();
    we = 1'b0; sb.push_back(16'h1234); #1;
    check("commit7_p0", port(rd, 0));

    we = 1'b1; wa = 6'd63; wd = 16'h6363;
    tick();
    we = 1'b0; ra = {6'd63, 6'd7};
    sb.push_back(16'h1234); sb.push_back(16'h6363); #1;
    check("rd7_p0", port(rd, 0));
    check("rd63_p1", port(rd, 1));

    // --- Register 0 (hardwired zero when the option is built in) ------------
    we = 1'b1; wa = 6'd0; wd = 16'hFFFF; ra = {6'd5, 6'd0};
    sb.push_back(Reg0Exp); #1;
    check("reg0_bypass", port(rd, 0));
    tick();
    we = 1'b0; sb.push_back(Reg0Exp); sb.push_back(16'hBEEF); #1;
    check("reg0_read", port(rd, 0));
    check("rd5_again", port(rd, 1));

    // --- Clear request; writes held through the sweep are dropped -----------
    clr_req = 1'b1; we = 1'b1; wa = 6'd9; wd = 16'h5555; ra = {6'd5, 6'd9};
    tick();
    sb.push_back(1); check("clr_busy", busy);
    sb.push_back(0); check("clr_rd_forced", rd);
    tick(); tick();
    clr_req = 1'b0;
    wait_sweep(1'b0, c, e);
    we = 1'b0;
    sb.push_back(64); check("clr_sweep_len", 2 + c);
    sb.push_back(0);  check("clr_early_done", e);
    sb.push_back(1);  check("clr_done", done);
    sb.push_back(0); sb.push_back(0); #1;
    check("rd9_after_clr", port(rd, 0));
    check("rd5_after_clr", port(rd, 1));
    ra = {6'd63, 6'd7};
    tick();
    sb.push_back(0); check("clr_done_single", done);
    sb.push_back(0); check("rd7_63_after_clr", rd);

    // --- Reset during a sweep -------------------------------------------------
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (30) tick();
    rst = 1'b1; #1;
    sb.push_back(1); check("midrst_busy", busy);
    sb.push_back(0); check("midrst_done", done);
    tick(); tick();
    rst = 1'b0;
    wait_sweep(1'b0, c, e);
    sb.push_back(64); check("midrst_sweep_len", c);
    sb.push_back(0);  check("midrst_early_done", e);
    sb.push_back(1);  check("midrst_done_end", done);

    // --- 48-entry, 4-port instance -------------------------------------------
    rst_b = 1'b0;
    wait_sweep(1'b1, c, e);
    sb.push_back(48); check("b_sweep_len", c);
    sb.push_back(0);  check("b_early_done", e);
    sb.push_back(1);  check("b_done", done_b);
    we_b = 1'b1; wa_b = 6'd47; wd_b = 16'h4747;
    tick();
    wa_b = 6'd50; wd_b = 16'hABCD; ra_b = {6'd47, 6'd18, 6'd2, 6'd50};
    sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(16'h4747); #1;
    check("b_bypass50", port(rd_b, 0));
    check("b_rd2", port(rd_b, 1));
    check("b_rd18", port(rd_b, 2));
    check("b_rd47", port(rd_b, 3));
    tick();
    we_b = 1'b0;
    sb.push_back(0); sb.push_back(0); sb.push_back(0); #1;
    check("b_rd50", port(rd_b, 0));
    check("b_rd2_alias", port(rd_b, 1));
    check("b_rd18_alias", port(rd_b, 2));
    ra_b = {4{6'd47}};
    for (int p = 0; p < 4; p++) sb.push_back(16'h4747);
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("b_same47_p%0d", p), port(rd_b, p));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-read-port register file. Replaces the single-address 16-bit register file in the datapath.
- Independent write address.
- N combinational read ports with write-through bypass.
- Hardware clear sequencer that zeroes every entry after reset or on request.
- Sits between the instruction decoder (addresses) and the ALU (operands).

Parameters:
AddressWidth, 6, bits per register address
RegisterHeight, 1 << AddressWidth, number of registers (must be ≤ 2**AddressWidth, ≥ 2)
RegisterWidth, 16, bits per register
ReadPorts, 2, number of independent read ports (≥ 1)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
ClearRequest  input  1  level; starts a full clear sweep when sampled high in IDLE
WriteEnable  input  1  write strobe, sampled on rising Clock
WriteAddress  input  AddressWidth  register to write
WriteData  input  RegisterWidth  data to write
ReadAddress  input  ReadPorts*AddressWidth  packed; port p uses bits [p*AddressWidth +: AddressWidth]
ReadData  output  ReadPorts*RegisterWidth  packed; port p on bits [p*RegisterWidth +: RegisterWidth]
Busy  output  1  high while the clear sweep runs
ClearDone  output  1  single-cycle pulse when a sweep completes

Behaviour:
- Reset asserted: FSM forced to CLEAR, ClearIndex = 0, Busy = 1, ClearDone = 0, ReadData = 0.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM has two states, IDLE and CLEAR.
- CLEAR:
  - Each cycle writes 0 to Registers[ClearIndex], then ClearIndex increments.
  - The cycle with ClearIndex == RegisterHeight-1 writes the last entry. Next state is IDLE, and ClearDone = 1 for exactly that following cycle.
  - A sweep takes exactly RegisterHeight cycles; default is 64.
- In CLEAR:
  - Busy = 1.
  - All ReadData ports forced to 0.
  - WriteEnable ignored; the write is dropped, not queued.
  - ClearRequest ignored; the sweep does not restart.
- IDLE:
  - Busy = 0.
  - ClearRequest = 1 → CLEAR next cycle with ClearIndex = 0.
  - If WriteEnable is high in the same cycle, that write still commits; the sweep later overwrites it.
- Write: in IDLE with WriteEnable = 1, Registers[WriteAddress] <= WriteData on the rising Clock.
  - WriteAddress ≥ RegisterHeight: write discarded.
- Read: combinational.
  - ReadData[p] = Registers[ReadAddress[p]].
  - Bypass: if WriteEnable = 1 and ReadAddress[p] == WriteAddress in IDLE, ReadData[p] = WriteData in the same cycle.
  - ReadAddress ≥ RegisterHeight reads 0.
- Multiple ports may read the same address simultaneously; all return identical data.
- Reset asserted mid-sweep: sweep restarts at index 0; no ClearDone pulse is emitted for the aborted sweep.
- ClearIndex width is AddressWidth; no wrap-around beyond RegisterHeight-1.

Optional Feature:
REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Any port reading address 0 returns 0, including under bypass.
  - Storage for entry 0 may be omitted; the sweep still takes RegisterHeight cycles.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset pulse, then release → Busy = 1 for 64 cycles, ClearDone high for one cycle on cycle 64, every address then reads 0x0000 on both ports.
2. IDLE: write 0xBEEF to address 5, then read port 0 = 5, port 1 = 5 → both return 0xBEEF. Write 0x1234 to address 7 while port 0 reads 7 → port 0 shows 0x1234 in the same cycle (bypass).
3. ClearRequest pulsed with registers holding non-zero data; WriteEnable held with address 9 / 0x5555 throughout the sweep → writes dropped; after ClearDone, address 9 reads 0x0000.
4. Reset asserted at sweep cycle 30 → sweep restarts; Busy stays 1 for a further 64 cycles after release; no ClearDone before that.
5. With REGFILE_ZERO_REG_EN: write 0xFFFF to address 0 → reads 0x0000 (also under bypass). Without the macro → reads 0xFFFF.
6. ReadPorts = 4, RegisterHeight = 48, AddressWidth = 6 → sweep 48 cycles. Read/write at address 50 → write discarded, read returns 0.
